// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - stack operation codes, sequencer states and byte-count lookup
package stack_pkg;

    localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_PUSH1 = 3'd1,
        OP_PUSH2 = 3'd2,
        OP_PUSH3 = 3'd3,
        OP_PULL1 = 3'd4,
        OP_PULL2 = 3'd5,
        OP_PULL3 = 3'd6,
        OP_LOAD  = 3'd7
    } stack_op_t;

    typedef enum logic [2:0] {
        STATE_IDLE     = 3'd0,
        STATE_PUSH     = 3'd1,
        STATE_PULL_INC = 3'd2,
        STATE_PULL_RD  = 3'd3,
        STATE_LOAD     = 3'd4,
        STATE_DONE     = 3'd5
    } stack_state_t;

    function automatic logic [1:0] op_bytes(input stack_op_t op);
        case (op)
            OP_PUSH1, OP_PULL1: return 2'd1;
            OP_PUSH2, OP_PULL2: return 2'd2;
            OP_PUSH3, OP_PULL3: return 2'd3;
            default:            return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// rtl/stack_sequencer_if.sv - decode request, SP strobe and stack-page bus signals
interface stack_sequencer_if;
    import stack_pkg::*;

    logic        op_req;
    stack_op_t   op_code;
    logic        busy;
    logic        op_done;
    logic [7:0]  sp_value;
    logic        sp_increment;
    logic        sp_decrement;
    logic        sp_load;
    logic [15:0] stack_addr;
    logic        mem_we;
    logic        mem_re;
    logic [1:0]  byte_sel;
    logic [7:0]  mem_rdata;
    logic [7:0]  pull_data;
    logic        pull_valid;
    logic        wrap_err;

    modport master (
        output op_req, op_code, sp_value, mem_rdata,
        input  busy, op_done, sp_increment, sp_decrement, sp_load,
               stack_addr, mem_we, mem_re, byte_sel, pull_data, pull_valid, wrap_err
    );

    modport slave (
        input  op_req, op_code, sp_value, mem_rdata,
        output busy, op_done, sp_increment, sp_decrement, sp_load,
               stack_addr, mem_we, mem_re, byte_sel, pull_data, pull_valid, wrap_err
    );
endinterface

// File: rtl/stack_wrap_monitor.sv
// rtl/stack_wrap_monitor.sv - sticky flag for pushes at SP=00 and pull increments at SP=FF
module stack_wrap_monitor (
    input  logic       fclk,
    input  logic       resb,
    input  logic       push_i,
    input  logic       inc_i,
    input  logic       clear_i,
    input  logic [7:0] sp_value_i,
    output logic       wrap_err_o
);
    logic wrap_q;

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            wrap_q <= 1'b0;
        end else if (clear_i) begin
            wrap_q <= 1'b0;
        end else if ((push_i && sp_value_i == 8'h00) || (inc_i && sp_value_i == 8'hFF)) begin
            wrap_q <= 1'b1;
        end
    end

    assign wrap_err_o = wrap_q;
endmodule

// File: rtl/stack_sequencer.sv
// rtl/stack_sequencer.sv - 65C02 stack push/pull/TXS sequencer; STACK_WRAP_DETECT_EN builds the wrap flag
module stack_sequencer
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
    input  logic              fclk,
    input  logic              resb,
    stack_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_IDLE     = STATE_IDLE;
    localparam logic [2:0] ST_PUSH     = STATE_PUSH;
    localparam logic [2:0] ST_PULL_INC = STATE_PULL_INC;
    localparam logic [2:0] ST_PULL_RD  = STATE_PULL_RD;
    localparam logic [2:0] ST_LOAD     = STATE_LOAD;
    localparam logic [2:0] ST_DONE     = STATE_DONE;

    logic [2:0] state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] pull_data_q;
    logic       pull_valid_q;
    logic       last_byte;

    assign last_byte = (sel_q == cnt_q - 2'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_req) begin
                    cnt_d = op_bytes(bus.op_code);
                    sel_d = 2'd0;
                    case (bus.op_code)
                        OP_PUSH1, OP_PUSH2, OP_PUSH3: state_d = ST_PUSH;
                        OP_PULL1, OP_PULL2, OP_PULL3: state_d = ST_PULL_INC;
                        OP_LOAD:                      state_d = ST_LOAD;
                        default:                      state_d = ST_DONE;
                    endcase
                end
            end
            ST_PUSH: begin
                sel_d = sel_q + 2'd1;
                if (last_byte) state_d = ST_DONE;
            end
            ST_PULL_INC: state_d = ST_PULL_RD;
            ST_PULL_RD: begin
                sel_d   = sel_q + 2'd1;
                state_d = last_byte ? ST_DONE : ST_PULL_INC;
            end
            ST_LOAD: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            sel_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    // Pulled byte is registered so the datapath sees it the cycle after mem_re.
    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            pull_data_q  <= 8'h00;
            pull_valid_q <= 1'b0;
        end else begin
            pull_valid_q <= (state_q == ST_PULL_RD);
            if (state_q == ST_PULL_RD) pull_data_q <= bus.mem_rdata;
        end
    end

    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.op_done      = (state_q == ST_DONE);
    assign bus.sp_decrement = (state_q == ST_PUSH);
    assign bus.sp_increment = (state_q == ST_PULL_INC);
    assign bus.sp_load      = (state_q == ST_LOAD);
    assign bus.mem_we       = (state_q == ST_PUSH);
    assign bus.mem_re       = (state_q == ST_PULL_RD);
    assign bus.stack_addr   = (state_q == ST_PUSH || state_q == ST_PULL_RD)
                              ? {STACK_PAGE, bus.sp_value} : 16'h0000;
    assign bus.byte_sel     = (state_q == ST_PUSH || state_q == ST_PULL_INC || state_q == ST_PULL_RD)
                              ? sel_q : 2'd0;
    assign bus.pull_data    = pull_data_q;
    assign bus.pull_valid   = pull_valid_q;

`ifdef STACK_WRAP_DETECT_EN
    stack_wrap_monitor u_wrap (
        .fclk       (fclk),
        .resb       (resb),
        .push_i     (state_q == ST_PUSH),
        .inc_i      (state_q == ST_PULL_INC),
        .clear_i    (state_q == ST_LOAD),
        .sp_value_i (bus.sp_value),
        .wrap_err_o (bus.wrap_err)
    );
`else
    assign bus.wrap_err = 1'b0;
`endif

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Sequences the 65C02 stack pointer register and stack-page memory accesses for multi-byte push/pull operations (PHA/PHP, PLA/PLP, JSR, RTS, BRK/IRQ/NMI, RTI) and TXS. Accepts one stack operation at a time from instruction decode and emits one-cycle SP increment, decrement and load strobes. Drives the stack-page address, read/write strobes and byte index toward the bus interface, and returns pulled bytes to the datapath.

## Interface
- STACK_PAGE, 8'h01, high address byte for every stack access.
- fclk  in  1  core clock; all state changes on rising edge.
- resb  in  1  asynchronous, active-low reset.
- op_req  in  1  operation request; sampled only in IDLE.
- op_code  in  3  stack_op_t: NOP, PUSH1, PUSH2, PUSH3, PULL1, PULL2, PULL3, LOAD.
- busy  out  1  high whenever state is not IDLE.
- op_done  out  1  one-cycle pulse when the operation completes.
- sp_value  in  8  current stack pointer value.
- sp_increment  out  1  one-cycle SP +1 strobe.
- sp_decrement  out  1  one-cycle SP −1 strobe.
- sp_load  out  1  one-cycle SP load strobe (TXS).
- stack_addr  out  16  {STACK_PAGE, sp_value} during accesses, else 16'h0000.
- mem_we  out  1  write strobe for pushes.
- mem_re  out  1  read strobe for pulls.
- byte_sel  out  2  index (0..2) of the byte being transferred.
- mem_rdata  in  8  read data, valid in the mem_re cycle.
- pull_data  out  8  registered pulled byte.
- pull_valid  out  1  one-cycle pulse, cycle after mem_re.
- wrap_err  out  1  sticky SP wrap flag (see Configuration).

## Operation
- States: IDLE, PUSH, PULL_INC, PULL_RD, LOAD, DONE.
- IDLE with op_req=1: latch op_code, set byte counter n = 1/2/3, byte_sel=0.
  - PUSHn goes to PUSH; PULLn goes to PULL_INC; LOAD goes to LOAD.
  - NOP and undefined codes go directly to DONE.
- PUSH, one cycle per byte:
  - mem_we=1, stack_addr={page,SP}, sp_decrement=1.
  - Then byte_sel+1.
  - After byte n−1, go to DONE.
- PULL_INC: sp_increment=1, then go to PULL_RD.
- PULL_RD:
  - mem_re=1, stack_addr={page,SP} (SP already incremented).
  - Capture mem_rdata into pull_data; pull_valid pulses the next cycle.
  - Next state is PULL_INC for remaining bytes, else DONE.
- LOAD: sp_load=1 for one cycle, then DONE.
- DONE: op_done=1 for one cycle, then IDLE. op_req is ignored while busy.
- Byte order is byte_sel 0 first for both push and pull. The caller maps PCH/PCL/P.
- SP arithmetic is 8-bit modulo 256. The stack page never changes.
- At most one of sp_increment, sp_decrement, sp_load is high in any cycle.

## Timing
- Reset values: state=IDLE, all outputs 0, pull_data=8'h00, wrap_err=0.
- Latency, with request accepted at edge k:
  - PUSHn: write strobes in cycles k+1..k+n; op_done in cycle k+n+1.
  - PULLn: 2n cycles of INC/RD; op_done in cycle k+2n+1.
  - LOAD and NOP: op_done in k+2 and k+1 respectively.
- The earliest next accept is the edge after the op_done cycle (IDLE).
- sp_value must reflect a strobe by the following cycle. The sequencer does no internal SP prediction.
- resb asserted mid-operation: immediately IDLE, all strobes low. The partial operation is abandoned with no op_done.

## Configuration
- STACK_WRAP_DETECT_EN defined:
  - wrap_err is set when a push occurs at SP=8'h00, or a PULL_INC occurs at SP=8'hFF.
  - It stays set until resb or a LOAD operation clears it.
  - It never alters sequencing.
- Not defined: wrap_err is tied 0 and no detection logic is built.

## Structure
- Package stack_pkg holds:
  - stack_op_t enum (3-bit).
  - stack_state_t enum.
  - STACK_PAGE_DEFAULT=8'h01.
  - Byte-count lookup function op_bytes(stack_op_t).
- Optional sub-module stack_wrap_monitor holds the wrap detect and sticky flag. It is instantiated only under STACK_WRAP_DETECT_EN.

## Test plan
- PUSH3 with SP=8'hFD:
  - Writes at 01FD/01FC/01FB with byte_sel 0,1,2, one sp_decrement each.
  - op_done 4 cycles after accept.
- PULL2 with SP=8'hFB, memory 01FC=8'h34, 01FD=8'h12:
  - pull_data 8'h34 then 8'h12.
  - Alternating inc/read, op_done at cycle 5.
- LOAD: exactly one sp_load pulse, op_done at k+2; wrap_err cleared.
- PUSH1 at SP=8'h00:
  - Write to 0100, SP wraps to FF.
  - wrap_err=1 with macro, 0 without.
- resb low during the second byte of PULL3: all strobes drop asynchronously, busy=0, no op_done; a new PUSH1 after release works.
- op_req held high through a PUSH2 and an undefined code:
  - Second request accepted only after op_done.
  - The undefined code yields op_done at k+1 with no strobes.
